bus_arb: RTL and testbench
==========================

BUS_ARB -- requirements
Module: bus_arb

Interface
REQ-001 Parameter MAX_TENURE, default 16: cycles an unlocked owner may hold the bus while the other master waits.
REQ-002 clk  input  1  clock; all state updates on its rising edge.
REQ-003 rstn  input  1  reset; asynchronous, active-low.
REQ-004 m0_bus_req / m1_bus_req  input  1 each  bus request from master 0 (CPU) / master 1 (DMA).
REQ-005 m0_bus_lock / m1_bus_lock  input  1 each  owner requests no preemption.
REQ-006 m0_bus_grant / m1_bus_grant  output  1 each  bus ownership indication, registered.
REQ-007 m0_addr / m1_addr  input  32 each  master address.
REQ-008 m0_we / m1_we  input  1 each  master write enable.
REQ-009 m0_wd / m1_wd  input  32 each  master write data.
REQ-010 m0_byte_en / m1_byte_en  input  4 each  master byte enables.
REQ-011 m0_rd / m1_rd  output  32 each  read data returned to masters.
REQ-012 s_addr  output  32  address to slave bus.
REQ-013 s_we  output  1  write enable to slave bus.
REQ-014 s_wd  output  32  write data to slave bus.
REQ-015 s_byte_en  output  4  byte enables to slave bus.
REQ-016 s_rd  input  32  slave read data.

Function
REQ-017 FSM states: IDLE, OWN0, OWN1; m0_bus_grant = (state==OWN0), m1_bus_grant = (state==OWN1).
REQ-018 Grant latency: request sampled at cycle N -> grant high at cycle N+1; no combinational req->grant path.
REQ-019 IDLE: only one request high -> go to that master's OWN state; none -> stay in IDLE.
REQ-020 IDLE, both requesting: the master not granted last wins; last-granted pointer resets to 1, so master 0 wins first.
REQ-021 OWNx, m<x>_bus_req low -> go to OWNy if m<y>_bus_req is high, else IDLE; grant therefore switches masters in one cycle with no idle gap.
REQ-022 Tenure counter: cleared on each state change; increments each cycle in OWNx; saturates at MAX_TENURE-1.
REQ-023 Preemption: in OWNx with m<x>_bus_req high, m<x>_bus_lock low, m<y>_bus_req high and counter == MAX_TENURE-1 -> go to OWNy.
REQ-024 A locked owner is never preempted; lock is sampled every cycle, so releasing lock after saturation preempts on the next edge.
REQ-025 Lock from a non-owner has no effect.
REQ-026 Slave mux: OWN0 drives s_* from m0_*; OWN1 drives s_* from m1_*; IDLE drives s_addr=0, s_we=0, s_wd=0, s_byte_en=0.
REQ-027 s_we is never asserted on behalf of a master whose grant is low.
REQ-028 m0_rd and m1_rd both equal s_rd; masters use read data only while granted.
REQ-029 At most one grant is high in any cycle.

Reset
REQ-030 While rstn is low: state=IDLE, both grants 0, tenure counter 0, last-granted pointer=1, and s_* outputs at their IDLE values.
REQ-031 Reset asserted mid-transfer drops the grant immediately, without waiting for a clock edge.
REQ-032 After rstn deasserts, the first grant occurs at the first edge at which a request is sampled.

Structure
REQ-033 Package bus_arb_pkg holds the state enum and the MAX_TENURE default constant.
REQ-034 Sub-module bus_arb_mux implements the combinational master-to-slave select and IDLE zeroing; the FSM and counter stay in bus_arb.

Verification
REQ-035 After reset, m1_bus_req=1 at edge 0 -> m1_bus_grant=1 at edge 1; s_addr = m1_addr = 0x1000_0000.
REQ-036 Both requests raised together from reset -> m0 granted first; m0 drops req -> m1 granted on the next edge with no IDLE cycle.
REQ-037 m0 owns unlocked, m1 requesting, MAX_TENURE=16 -> m1_bus_grant rises exactly 16 cycles after m0_bus_grant rose.
REQ-038 Same as REQ-037 with m0_bus_lock=1 for 40 cycles -> m0 keeps the grant for all 40; lock drop -> m1 granted on the next edge.
REQ-039 rstn pulled low while m1 owns with m1_we=1 -> m1_bus_grant=0 and s_we=0 before the next clock edge.
REQ-040 Throughout all scenarios, an assertion checks that m0_bus_grant and m1_bus_grant are never both 1.

Source files
------------

// File: rtl/bus_arb_pkg.sv
// Shared types and constants for the two-master bus arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package bus_arb_pkg;

  // Default number of cycles an unlocked owner keeps the bus while the other master waits.
  localparam int MAX_TENURE_DEF = 16;

  // Arbiter ownership states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } state_e;

  // One master's request-side bus fields, bundled so the mux selects them as a unit.
  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wd;
    logic [3:0]  byte_en;
  } bus_req_t;

endpackage

// File: rtl/bus_arb_mux.sv
// Master-to-slave request mux: forwards the owning master's fields, zero when idle.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the slave side follows the registered ownership state.
module bus_arb_mux
  import bus_arb_pkg::*;
(
  input  state_e   i_state,
  input  bus_req_t i_m0,
  input  bus_req_t i_m1,
  output bus_req_t o_s
);

  // Select the owner's fields; anything other than an owning state drives all zeros,
  // so a write strobe can never reach the slave for a master that is not granted.
  always_comb begin
    o_s = '0;
    case (i_state)
      ST_OWN0: o_s = i_m0;
      ST_OWN1: o_s = i_m1;
      default: o_s = '0;
    endcase
  end

endmodule

// File: rtl/bus_arb.sv
// Two-master (CPU/DMA) bus arbiter with alternating priority, tenure preemption and lock.
// Latency: request sampled at edge N gives grant after edge N; no comb req->grant path.
// Backpressure: waiting master holds its request; owner holds until release or preemption.
module bus_arb
  import bus_arb_pkg::*;
#(
  parameter int MAX_TENURE = MAX_TENURE_DEF
) (
  input  logic        clk,
  input  logic        rstn,
  // master 0 (CPU)
  input  logic        m0_bus_req,
  input  logic        m0_bus_lock,
  output logic        m0_bus_grant,
  input  logic [31:0] m0_addr,
  input  logic        m0_we,
  input  logic [31:0] m0_wd,
  input  logic [3:0]  m0_byte_en,
  output logic [31:0] m0_rd,
  // master 1 (DMA)
  input  logic        m1_bus_req,
  input  logic        m1_bus_lock,
  output logic        m1_bus_grant,
  input  logic [31:0] m1_addr,
  input  logic        m1_we,
  input  logic [31:0] m1_wd,
  input  logic [3:0]  m1_byte_en,
  output logic [31:0] m1_rd,
  // slave bus
  output logic [31:0] s_addr,
  output logic        s_we,
  output logic [31:0] s_wd,
  output logic [3:0]  s_byte_en,
  input  logic [31:0] s_rd
);

  // Counter only needs to reach MAX_TENURE-1; keep at least one bit for MAX_TENURE==1.
  localparam int            CW       = (MAX_TENURE > 1) ? $clog2(MAX_TENURE) : 1;
  localparam logic [CW-1:0] TEN_LAST = CW'(MAX_TENURE - 1);

  state_e          r_state;
  state_e          w_state_nxt;
  logic [CW-1:0]   r_tenure;
  logic [CW-1:0]   w_tenure_nxt;
  logic            r_last;       // 1: master 1 was granted most recently
  logic            w_last_nxt;
  logic            w_tenure_up;
  logic            w_preempt0;   // master 0 owns and must yield to master 1
  logic            w_preempt1;   // master 1 owns and must yield to master 0
  bus_req_t        w_m0_req;
  bus_req_t        w_m1_req;
  bus_req_t        w_s_req;

  // Preemption only once the owner has used its full tenure, is not locked,
  // and the other master is actually waiting.
  assign w_tenure_up = (r_tenure == TEN_LAST);
  assign w_preempt0  = m1_bus_req && !m0_bus_lock && w_tenure_up;
  assign w_preempt1  = m0_bus_req && !m1_bus_lock && w_tenure_up;

  // Next-state: idle picks by request and fairness pointer; owners release or get preempted.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (m0_bus_req && m1_bus_req) begin
          w_state_nxt = r_last ? ST_OWN0 : ST_OWN1;
        end else if (m0_bus_req) begin
          w_state_nxt = ST_OWN0;
        end else if (m1_bus_req) begin
          w_state_nxt = ST_OWN1;
        end
      end
      ST_OWN0: begin
        // Releasing owner hands straight over to a waiting master without an idle gap.
        if (!m0_bus_req) begin
          w_state_nxt = m1_bus_req ? ST_OWN1 : ST_IDLE;
        end else if (w_preempt0) begin
          w_state_nxt = ST_OWN1;
        end
      end
      ST_OWN1: begin
        if (!m1_bus_req) begin
          w_state_nxt = m0_bus_req ? ST_OWN0 : ST_IDLE;
        end else if (w_preempt1) begin
          w_state_nxt = ST_OWN0;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Tenure counter: restart on any ownership change, count while owned, saturate.
  always_comb begin
    w_tenure_nxt = r_tenure;
    if (w_state_nxt != r_state) begin
      w_tenure_nxt = '0;
    end else if ((r_state != ST_IDLE) && !w_tenure_up) begin
      w_tenure_nxt = r_tenure + 1'b1;
    end
  end

  // Fairness pointer follows whichever master is being newly granted.
  always_comb begin
    w_last_nxt = r_last;
    if ((w_state_nxt == ST_OWN0) && (r_state != ST_OWN0)) begin
      w_last_nxt = 1'b0;
    end else if ((w_state_nxt == ST_OWN1) && (r_state != ST_OWN1)) begin
      w_last_nxt = 1'b1;
    end
  end

  // State register; reset parks in IDLE with master 1 marked last so master 0 wins first.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state  <= ST_IDLE;
      r_tenure <= '0;
      r_last   <= 1'b1;
    end else begin
      r_state  <= w_state_nxt;
      r_tenure <= w_tenure_nxt;
      r_last   <= w_last_nxt;
    end
  end

  // Grants decode straight from the state flop, so reset drops them asynchronously.
  assign m0_bus_grant = (r_state == ST_OWN0);
  assign m1_bus_grant = (r_state == ST_OWN1);

  assign w_m0_req = '{addr: m0_addr, we: m0_we, wd: m0_wd, byte_en: m0_byte_en};
  assign w_m1_req = '{addr: m1_addr, we: m1_we, wd: m1_wd, byte_en: m1_byte_en};

  bus_arb_mux u_mux (
    .i_state (r_state),
    .i_m0    (w_m0_req),
    .i_m1    (w_m1_req),
    .o_s     (w_s_req)
  );

  assign s_addr    = w_s_req.addr;
  assign s_we      = w_s_req.we;
  assign s_wd      = w_s_req.wd;
  assign s_byte_en = w_s_req.byte_en;

  // Read data is broadcast; each master only consumes it while granted.
  assign m0_rd = s_rd;
  assign m1_rd = s_rd;

endmodule

// File: tb/tb_bus_arb.sv
module tb_bus_arb;

  localparam int TEN = 16;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        m0_bus_req, m0_bus_lock, m0_bus_grant, m0_we;
  logic        m1_bus_req, m1_bus_lock, m1_bus_grant, m1_we;
  logic [31:0] m0_addr, m0_wd, m0_rd, m1_addr, m1_wd, m1_rd;
  logic [3:0]  m0_byte_en, m1_byte_en, s_byte_en;
  logic [31:0] s_addr, s_wd, s_rd;
  logic        s_we;

  int n_checks = 0;
  int n_errors = 0;
  int cyc_n    = 0;

  // reference model: owner is -1 (nobody), 0 or 1; held = cycles since grant
  int m_owner = -1;
  int m_held  = 0;
  int m_last  = 1;

  bus_arb #(.MAX_TENURE(TEN)) dut (
    .clk(clk), .rstn(rstn),
    .m0_bus_req(m0_bus_req), .m0_bus_lock(m0_bus_lock), .m0_bus_grant(m0_bus_grant),
    .m0_addr(m0_addr), .m0_we(m0_we), .m0_wd(m0_wd), .m0_byte_en(m0_byte_en), .m0_rd(m0_rd),
    .m1_bus_req(m1_bus_req), .m1_bus_lock(m1_bus_lock), .m1_bus_grant(m1_bus_grant),
    .m1_addr(m1_addr), .m1_we(m1_we), .m1_wd(m1_wd), .m1_byte_en(m1_byte_en), .m1_rd(m1_rd),
    .s_addr(s_addr), .s_we(s_we), .s_wd(s_wd), .s_byte_en(s_byte_en), .s_rd(s_rd)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_held  = 0;
    m_last  = 1;
  endtask

  // One rising edge of the arbitration rules, using the inputs present at the edge.
  task automatic model_step();
    bit req [2];
    bit lock[2];
    int nxt;
    req[0] = m0_bus_req;  req[1] = m1_bus_req;
    lock[0] = m0_bus_lock; lock[1] = m1_bus_lock;
    nxt = m_owner;
    if (m_owner < 0) begin
      if (req[0] && req[1]) nxt = 1 - m_last;
      else if (req[0])      nxt = 0;
      else if (req[1])      nxt = 1;
    end else begin
      if (!req[m_owner])
        nxt = req[1 - m_owner] ? 1 - m_owner : -1;
      else if (!lock[m_owner] && req[1 - m_owner] && m_held >= TEN - 1)
        nxt = 1 - m_owner;
    end
    if (nxt != m_owner) begin
      m_held = 0;
      if (nxt >= 0) m_last = nxt;
    end else if (m_owner >= 0) begin
      m_held++;
    end
    m_owner = nxt;
  endtask

  task automatic compare_all();
    logic [31:0] e_addr, e_wd;
    logic        e_we;
    logic [3:0]  e_be;
    e_addr = 0; e_wd = 0; e_we = 0; e_be = 0;
    if (m_owner == 0) begin
      e_addr = m0_addr; e_wd = m0_wd; e_we = m0_we; e_be = m0_byte_en;
    end else if (m_owner == 1) begin
      e_addr = m1_addr; e_wd = m1_wd; e_we = m1_we; e_be = m1_byte_en;
    end
    check("grant0", {31'b0, m0_bus_grant}, {31'b0, m_owner == 0});
    check("grant1", {31'b0, m1_bus_grant}, {31'b0, m_owner == 1});
    check("s_addr", s_addr, e_addr);
    check("s_we", {31'b0, s_we}, {31'b0, e_we});
    check("s_wd", s_wd, e_wd);
    check("s_byte_en", {28'b0, s_byte_en}, {28'b0, e_be});
    check("m0_rd", m0_rd, s_rd);
    check("m1_rd", m1_rd, s_rd);
  endtask

  task automatic cyc();
    @(posedge clk);
    if (!rstn) model_reset();
    else       model_step();
    cyc_n++;
    #1;
    compare_all();
  endtask

  task automatic clear_inputs();
    m0_bus_req = 0; m0_bus_lock = 0; m0_addr = 32'h0000_0100; m0_we = 0;
    m0_wd = 32'hA0A0_A0A0; m0_byte_en = 4'hF;
    m1_bus_req = 0; m1_bus_lock = 0; m1_addr = 32'h1000_0000; m1_we = 0;
    m1_wd = 32'hB1B1_B1B1; m1_byte_en = 4'h3;
    s_rd = 32'h5A5A_0001;
  endtask

  task automatic do_reset();
    rstn = 0;
    clear_inputs();
    m0_we = 1; m1_we = 1;   // a write strobe must still not leak while idle
    model_reset();
    #1;
    check("rst_g0", {31'b0, m0_bus_grant}, 0);
    check("rst_g1", {31'b0, m1_bus_grant}, 0);
    check("rst_s_we", {31'b0, s_we}, 0);
    check("rst_s_addr", s_addr, 0);
    compare_all();
    repeat (2) @(posedge clk);
    #1;
    rstn = 1;
    m0_we = 0; m1_we = 0;
  endtask

  // no two grants at once, ever
  always @(negedge clk) begin
    check("onehot", {31'b0, m0_bus_grant & m1_bus_grant}, 0);
    assert (!(m0_bus_grant && m1_bus_grant));
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    int got;
    int held;

    // single DMA request right out of reset
    do_reset();
    m1_bus_req = 1;
    cyc();
    check("r35_g1", {31'b0, m1_bus_grant}, 1);
    check("r35_addr", s_addr, 32'h1000_0000);

    // simultaneous requests: CPU first, then handover without idle
    do_reset();
    m0_bus_req = 1; m1_bus_req = 1;
    cyc();
    check("r36_g0", {31'b0, m0_bus_grant}, 1);
    m0_bus_req = 0;
    cyc();
    check("r36_g1", {31'b0, m1_bus_grant}, 1);
    check("r36_g0off", {31'b0, m0_bus_grant}, 0);

    // tenure preemption after exactly TEN cycles
    do_reset();
    m0_bus_req = 1;
    cyc();
    check("r37_g0", {31'b0, m0_bus_grant}, 1);
    t0 = cyc_n;
    m1_bus_req = 1;
    got = 0;
    for (int k = 0; k < 40 && got == 0; k++) begin
      cyc();
      if (m1_bus_grant) got = 1;
    end
    check("r37_found", got, 1);
    check("r37_gap", cyc_n - t0, TEN);

    // locked owner is not preempted; unlock hands over on the next edge
    do_reset();
    m0_bus_req = 1; m0_bus_lock = 1;
    cyc();
    check("r38_g0", {31'b0, m0_bus_grant}, 1);
    m1_bus_req = 1;
    held = 0;
    for (int k = 0; k < 40; k++) begin
      cyc();
      if (m0_bus_grant) held++;
    end
    check("r38_held", held, 40);
    m0_bus_lock = 0;
    cyc();
    check("r38_g1", {31'b0, m1_bus_grant}, 1);

    // asynchronous reset in the middle of a DMA write
    do_reset();
    m1_bus_req = 1; m1_we = 1;
    cyc();
    check("r39_g1_pre", {31'b0, m1_bus_grant}, 1);
    check("r39_we_pre", {31'b0, s_we}, 1);
    #2;
    rstn = 0;
    model_reset();
    #1;
    check("r39_g1", {31'b0, m1_bus_grant}, 0);
    check("r39_we", {31'b0, s_we}, 0);
    compare_all();
    @(posedge clk);
    #1;
    rstn = 1;
    clear_inputs();

    // randomized traffic with sticky requests and locks
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 11) == 0) m0_bus_req  = ~m0_bus_req;
      if ($urandom_range(0, 11) == 0) m1_bus_req  = ~m1_bus_req;
      if ($urandom_range(0, 19) == 0) m0_bus_lock = ~m0_bus_lock;
      if ($urandom_range(0, 19) == 0) m1_bus_lock = ~m1_bus_lock;
      m0_addr = $urandom; m0_wd = $urandom; m0_we = 1'($urandom); m0_byte_en = 4'($urandom);
      m1_addr = $urandom; m1_wd = $urandom; m1_we = 1'($urandom); m1_byte_en = 4'($urandom);
      s_rd = $urandom;
      cyc();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
